regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_wb_arbiter_if.sv | 49 ++++
 rtl/regfile_wb_arbiter_scoreboard.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 80 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
//   DATA_W   : register data width
//   ADDR_W   : register address width
//   NREG     : number of architectural registers
//   ZERO_REG : hardwired-zero register index; never written and never marked busy
//   wb_req_t : one writeback request (valid, destination, data)
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus between the execute/writeback units, the decode stage and the arbiter.
//   req0_*   : ALU writeback request and its ready
//   req1_*   : load/multicycle writeback request and its ready
//   wr_*     : register-file write port (RegWrite/WriteRegister/WriteData)
//   issue_*  : decode issue of an instruction that will write issue_addr
//   rd_addr* : decode source registers; stall flags a pending write on either
//   busy_vec : scoreboard state, bit i = register i has a write outstanding
// The slave modport is the arbiter side; master is the driving side.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_ready;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              stall;
    logic [NREG-1:0]   busy_vec;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  issue_valid, issue_addr, rd_addr1, rd_addr2,
        output req0_ready, req1_ready,
        output wr_en, wr_addr, wr_data,
        output issue_ready, stall, busy_vec
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output issue_valid, issue_addr, rd_addr1, rd_addr2,
        input  req0_ready, req1_ready,
        input  wr_en, wr_addr, wr_data,
        input  issue_ready, stall, busy_vec
    );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Scoreboard of destination registers with writes still outstanding.
//   clk, rst_n      : clock, asynchronous active-low reset
//   issue_valid/addr: decode issuing a writer of issue_addr
//   issue_ready     : issue accepted (no WAW conflict on issue_addr)
//   wr_en, wr_addr  : register-file write this cycle; clears the busy bit at its edge
//   rd_addr1/2      : decode source registers
//   stall           : a non-zero source register is still busy
//   busy_vec        : bit i = register i pending
module reg_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              stall,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    assign issue_ready = !busy_q[issue_addr] || (issue_addr == ZERO_REG);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (wr_en && (wr_addr != ZERO_REG))
            clr_mask[wr_addr] = 1'b1;
        if (issue_valid && issue_ready && (issue_addr != ZERO_REG))
            set_mask[issue_addr] = 1'b1;
    end

    // Clear first, then set: a new writer issued on the very edge the old
    // write lands keeps the register busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= (busy_q & ~clr_mask) | set_mask;
    end

    // No bypass: a reader waits until the cycle after the write edge.
    assign stall = (busy_q[rd_addr1] && (rd_addr1 != ZERO_REG)) ||
                   (busy_q[rd_addr2] && (rd_addr2 != ZERO_REG));

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the ALU writeback
// (req0) and the load/multicycle writeback (req1), and tracks pending
// destinations for decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of regfile_wb_arbiter_if (requests, write port,
//                issue/stall handshake, busy_vec)
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    wb_req_t req0;
    wb_req_t req1;
    wb_req_t sel;
    logic    gnt0;
    logic    gnt1;
    logic    rr_ptr;   // 0: req0 wins next contention, 1: req1 wins

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    assign req0 = '{valid: bus.req0_valid, addr: bus.req0_addr, data: bus.req0_data};
    assign req1 = '{valid: bus.req1_valid, addr: bus.req1_addr, data: bus.req1_data};

    // The write port never back-pressures, so any valid request gets a grant.
    always_comb begin
        gnt0 = req0.valid && (!req1.valid || !rr_ptr);
        gnt1 = req1.valid && (!req0.valid ||  rr_ptr);
        sel  = gnt1 ? req1 : req0;
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // Pointer moves only on contention, so a lone requester never loses priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= 1'b0;
        else if (req0.valid && req1.valid)
            rr_ptr <= ~rr_ptr;
    end

    // Registered write port; a grant to register 0 is consumed but not written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (sel.valid) begin
            wr_en_q   <= (sel.addr != ZERO_REG);
            wr_addr_q <= sel.addr;
            wr_data_q <= sel.data;
        end else begin
            wr_en_q   <= 1'b0;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

    reg_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (bus.issue_valid),
        .issue_addr  (bus.issue_addr),
        .issue_ready (bus.issue_ready),
        .wr_en       (wr_en_q),
        .wr_addr     (wr_addr_q),
        .rd_addr1    (bus.rd_addr1),
        .rd_addr2    (bus.rd_addr2),
        .stall       (bus.stall),
        .busy_vec    (bus.busy_vec)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run compared against a behavioural model of the arbiter and
// scoreboard rules.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    bit                m_busy [NREG];
    bit                m_rr;        // 1 when req1 is owed the next contention
    bit                m_wen;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_rr    = 1'b0;
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    task automatic exp_comb(output bit g0, output bit g1, output bit ir, output bit st);
        bit v0, v1;
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        if (v0 && v1) begin
            g1 = m_rr;
            g0 = !m_rr;
        end else begin
            g0 = v0;
            g1 = v1;
        end
        ir = (bus.issue_addr == 0) || !m_busy[bus.issue_addr];
        st = (bus.rd_addr1 != 0 && m_busy[bus.rd_addr1]) ||
             (bus.rd_addr2 != 0 && m_busy[bus.rd_addr2]);
    endtask

    task automatic model_edge();
        bit g0, g1, ir, st;
        if (!rst_n) begin
            model_reset();
            return;
        end
        exp_comb(g0, g1, ir, st);
        if (m_wen) m_busy[m_waddr] = 1'b0;
        if (bus.issue_valid && ir && bus.issue_addr != 0) m_busy[bus.issue_addr] = 1'b1;
        if (g0) begin
            m_wen = (bus.req0_addr != 0); m_waddr = bus.req0_addr; m_wdata = bus.req0_data;
        end else if (g1) begin
            m_wen = (bus.req1_addr != 0); m_waddr = bus.req1_addr; m_wdata = bus.req1_data;
        end else begin
            m_wen = 1'b0;
        end
        if (bus.req0_valid && bus.req1_valid) m_rr = !m_rr;
    endtask

    function automatic logic [NREG-1:0] model_busy_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic idle_inputs();
        bus.req0_valid  = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid  = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.issue_valid = 1'b0; bus.issue_addr = '0;
        bus.rd_addr1    = '0;   bus.rd_addr2   = '0;
    endtask

    // Advance one clock; model follows the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== '0 || bus.busy_vec !== '0)
            $display("FAIL reset_state: wr_en=%b wr_addr=%0d wr_data=%h busy=%h, required all zero",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy_vec);
        else n_pass++;
    endtask

    task automatic test_single_write();
        reset_dut();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (bus.req0_ready !== 1'b1) $display("FAIL single_ready: req0_ready=%b required 1", bus.req0_ready);
        else n_pass++;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd3 || bus.wr_data !== 32'hDEADBEEF)
            $display("FAIL single_write: wr_en=%b addr=%0d data=%h required 1/3/deadbeef",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd3 || bus.wr_data !== 32'hDEADBEEF)
            $display("FAIL single_idle: wr_en=%b addr=%0d data=%h required 0/3/deadbeef (held)",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        else n_pass++;
    endtask

    task automatic test_contention();
        int cnt0 = 0;
        int cnt1 = 0;
        reset_dut();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h1111;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'h2222;
        for (int c = 0; c < 4; c++) begin
            #1;
            cnt0 += int'(bus.req0_ready);
            cnt1 += int'(bus.req1_ready);
            n_checks++;
            if (bus.req0_ready !== (c % 2 == 0) || bus.req1_ready !== (c % 2 == 1))
                $display("FAIL contention_grant%0d: ready0=%b ready1=%b required %b/%b",
                         c, bus.req0_ready, bus.req1_ready, (c % 2 == 0), (c % 2 == 1));
            else n_pass++;
            tick();
            n_checks++;
            if (bus.wr_addr !== ((c % 2 == 0) ? 5'd1 : 5'd2))
                $display("FAIL contention_wr%0d: wr_addr=%0d required %0d",
                         c, bus.wr_addr, (c % 2 == 0) ? 1 : 2);
            else n_pass++;
        end
        idle_inputs();
        n_checks++;
        if (cnt0 != 2 || cnt1 != 2)
            $display("FAIL contention_count: ready0 cycles=%0d ready1 cycles=%0d required 2/2", cnt0, cnt1);
        else n_pass++;
    endtask

    task automatic test_stall();
        reset_dut();
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd5;
        #1;
        n_checks++;
        if (bus.issue_ready !== 1'b1) $display("FAIL stall_issue: issue_ready=%b required 1", bus.issue_ready);
        else n_pass++;
        tick();
        bus.issue_valid = 1'b0; bus.rd_addr1 = 5'd5;
        #1;
        n_checks++;
        if (bus.stall !== 1'b1 || bus.busy_vec[5] !== 1'b1)
            $display("FAIL stall_set: stall=%b busy5=%b required 1/1", bus.stall, bus.busy_vec[5]);
        else n_pass++;
        tick();
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd5; bus.req1_data = 32'h55;
        tick();
        bus.req1_valid = 1'b0;
        n_checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.stall !== 1'b1)
            $display("FAIL stall_pending: wr_en=%b wr_addr=%0d stall=%b required 1/5/1",
                     bus.wr_en, bus.wr_addr, bus.stall);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.stall !== 1'b0 || bus.busy_vec[5] !== 1'b0)
            $display("FAIL stall_release: stall=%b busy5=%b required 0/0", bus.stall, bus.busy_vec[5]);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_waw_and_set_wins();
        reset_dut();
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd7;
        tick();
        #1;
        n_checks++;
        if (bus.issue_ready !== 1'b0) $display("FAIL waw_ready: issue_ready=%b required 0", bus.issue_ready);
        else n_pass++;
        tick();
        bus.issue_valid = 1'b0;
        n_checks++;
        if (bus.busy_vec !== 32'h0000_0080)
            $display("FAIL waw_busy: busy=%h required 00000080", bus.busy_vec);
        else n_pass++;
        // Unissued write of 9 lands on the same edge as a new issue of 9.
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd9; bus.req0_data = 32'h99;
        tick();
        bus.req0_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd9;
        #1;
        n_checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd9 || bus.issue_ready !== 1'b1)
            $display("FAIL setwins_pre: wr_en=%b wr_addr=%0d issue_ready=%b required 1/9/1",
                     bus.wr_en, bus.wr_addr, bus.issue_ready);
        else n_pass++;
        tick();
        bus.issue_valid = 1'b0;
        n_checks++;
        if (bus.busy_vec[9] !== 1'b1 || bus.busy_vec[7] !== 1'b1)
            $display("FAIL setwins_busy: busy=%h required bits 7 and 9 set", bus.busy_vec);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_reg0();
        reset_dut();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd0; bus.req0_data = 32'h1;
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd0;
        #1;
        n_checks++;
        if (bus.req0_ready !== 1'b1 || bus.issue_ready !== 1'b1)
            $display("FAIL reg0_ready: req0_ready=%b issue_ready=%b required 1/1",
                     bus.req0_ready, bus.issue_ready);
        else n_pass++;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.busy_vec !== '0 || bus.stall !== 1'b0)
            $display("FAIL reg0_effect: wr_en=%b busy=%h stall=%b required 0/0/0",
                     bus.wr_en, bus.busy_vec, bus.stall);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        reset_dut();
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd12; bus.req1_data = 32'hC0FFEE;
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd2;
        tick();
        bus.issue_addr = 5'd4;
        tick();
        bus.issue_valid = 1'b0;
        n_checks++;
        if (bus.busy_vec !== 32'h0000_0014 || bus.wr_en !== 1'b1)
            $display("FAIL arst_pre: busy=%h wr_en=%b required 00000014/1", bus.busy_vec, bus.wr_en);
        else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy_vec !== '0 || bus.wr_en !== 1'b0)
            $display("FAIL arst_clear: busy=%h wr_en=%b required 0/0", bus.busy_vec, bus.wr_en);
        else n_pass++;
        model_reset();
        #2 rst_n = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd6;
        #1;
        n_checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
            $display("FAIL arst_first_grant: ready0=%b ready1=%b required 1/0",
                     bus.req0_ready, bus.req1_ready);
        else n_pass++;
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        bit g0, g1, ir, st;
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            bus.req0_valid  = 1'($urandom_range(0, 1));
            bus.req0_addr   = ADDR_W'($urandom_range(0, 7));
            bus.req0_data   = $urandom;
            bus.req1_valid  = 1'($urandom_range(0, 1));
            bus.req1_addr   = ADDR_W'($urandom_range(0, 7));
            bus.req1_data   = $urandom;
            bus.issue_valid = 1'($urandom_range(0, 1));
            bus.issue_addr  = ADDR_W'($urandom_range(0, 7));
            bus.rd_addr1    = ADDR_W'($urandom_range(0, 7));
            bus.rd_addr2    = ADDR_W'($urandom_range(0, 7));
            #1;
            exp_comb(g0, g1, ir, st);
            n_checks++;
            if (bus.req0_ready !== g0 || bus.req1_ready !== g1 || bus.issue_ready !== ir || bus.stall !== st)
                $display("FAIL rand_comb%0d: ready0/1=%b%b issue_ready=%b stall=%b required %b%b/%b/%b",
                         c, bus.req0_ready, bus.req1_ready, bus.issue_ready, bus.stall, g0, g1, ir, st);
            else n_pass++;
            tick();
            n_checks++;
            if (bus.wr_en !== m_wen || bus.busy_vec !== model_busy_vec() ||
                (m_wen && (bus.wr_addr !== m_waddr || bus.wr_data !== m_wdata)))
                $display("FAIL rand_seq%0d: wr_en=%b addr=%0d data=%h busy=%h required %b/%0d/%h/%h",
                         c, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy_vec,
                         m_wen, m_waddr, m_wdata, model_busy_vec());
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_single_write();
        test_contention();
        test_stall();
        test_waw_and_set_wins();
        test_reg0();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
